// File: rtl/perf_monitor.sv
// Pipeline performance monitor: windowed cycle/retire/event counters and fixed-point CPI via restoring division.
// Optional PERF_SATURATE_EN: counters stick at all-ones instead of wrapping to zero.
module perf_monitor #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned N_EVT     = 4,
  parameter int unsigned FRAC_W    = 8,
  parameter logic [31:0] END_VALUE = 32'h90
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   clear_i,
  input  logic                   retire_i,
  input  logic [N_EVT-1:0]       evt_i,
  input  logic                   result_valid_i,
  input  logic [31:0]            result_i,
  output logic [CNT_W-1:0]       cycles_o,
  output logic [CNT_W-1:0]       instr_o,
  output logic [N_EVT*CNT_W-1:0] evt_cnt_o,
  output logic [CNT_W-1:0]       cpi_o,
  output logic                   running_o,
  output logic                   cpi_valid_o,
  output logic                   overflow_o
);

  localparam int unsigned DW = CNT_W + FRAC_W;
  localparam int unsigned IW = $clog2(DW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, instr_q, cpi_q;
  logic [CNT_W-1:0] evt_q [N_EVT];
  logic             overflow_q;

  // quo_q starts as the dividend; each step shifts one dividend bit out and one quotient bit in.
  logic [DW-1:0]    quo_q;
  logic [CNT_W-1:0] rem_q;
  logic [IW-1:0]    iter_q;

  // Returns {blocked_or_wrapped, next_value} for one counter.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v, input logic en);
    logic full;
    full = en & (&v);
`ifdef PERF_SATURATE_EN
    return {full, v + CNT_W'(en & ~full)};
`else
    return {full, v + CNT_W'(en)};
`endif
  endfunction

  logic [CNT_W-1:0] cycles_d, instr_d;
  logic [CNT_W-1:0] evt_d [N_EVT];
  logic             cycles_full, instr_full;
  logic [N_EVT-1:0] evt_full;

  always_comb begin
    evt_full = '0;
    for (int k = 0; k < N_EVT; k++) begin
      evt_d[k] = '0;
    end
    {cycles_full, cycles_d} = bump(cycles_q, 1'b1);
    {instr_full, instr_d}   = bump(instr_q, retire_i);
    for (int k = 0; k < N_EVT; k++) begin
      {evt_full[k], evt_d[k]} = bump(evt_q[k], evt_i[k]);
    end
  end

  logic [CNT_W:0]   rem_sh;
  logic             rem_ge;
  logic [CNT_W-1:0] rem_nxt;
  logic [DW-1:0]    quo_nxt;
  logic [CNT_W-1:0] cpi_result;

  always_comb begin
    rem_sh     = {rem_q, quo_q[DW-1]};
    rem_ge     = rem_sh >= {1'b0, instr_q};
    rem_nxt    = rem_ge ? CNT_W'(rem_sh - {1'b0, instr_q}) : rem_sh[CNT_W-1:0];
    quo_nxt    = {quo_q[DW-2:0], rem_ge};
    cpi_result = (|quo_nxt[DW-1:CNT_W]) ? '1 : quo_nxt[CNT_W-1:0];
  end

  logic close;
  assign close = stop_i | (result_valid_i & (result_i == END_VALUE));

  logic restart, count_en, div_load, div_step, div_finish, div_by_zero;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    restart     = 1'b0;
    count_en    = 1'b0;
    div_load    = 1'b0;
    div_step    = 1'b0;
    div_finish  = 1'b0;
    div_by_zero = 1'b0;
    if (clear_i) begin
      state_d = S_IDLE;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d = S_RUN;
            restart = 1'b1;
          end
        end
        S_RUN: begin
          count_en = 1'b1;
          if (close) begin
            state_d  = S_DIV;
            div_load = 1'b1;
          end
        end
        S_DIV: begin
          if (instr_q == '0) begin
            state_d     = S_DONE;
            div_by_zero = 1'b1;
          end else begin
            div_step = 1'b1;
            if (iter_q == '0) begin
              state_d    = S_DONE;
              div_finish = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the event counter array is reset like any other register; all outputs must read 0 after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycles_q   <= '0;
      instr_q    <= '0;
      overflow_q <= 1'b0;
      cpi_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      iter_q     <= '0;
      for (int k = 0; k < N_EVT; k++) evt_q[k] <= '0;
    end else begin
      if (restart) begin
        cycles_q   <= '0;
        instr_q    <= '0;
        overflow_q <= 1'b0;
        cpi_q      <= '0;
        for (int k = 0; k < N_EVT; k++) evt_q[k] <= '0;
      end else if (count_en) begin
        cycles_q   <= cycles_d;
        instr_q    <= instr_d;
        overflow_q <= overflow_q | cycles_full | instr_full | (|evt_full);
        for (int k = 0; k < N_EVT; k++) evt_q[k] <= evt_d[k];
      end

      // The dividend is captured from the closing cycle's final count.
      if (div_load) begin
        quo_q  <= {cycles_d, {FRAC_W{1'b0}}};
        rem_q  <= '0;
        iter_q <= IW'(DW - 1);
      end else if (div_step) begin
        quo_q  <= quo_nxt;
        rem_q  <= rem_nxt;
        iter_q <= iter_q - 1'b1;
      end

      if (div_by_zero)     cpi_q <= '1;
      else if (div_finish) cpi_q <= cpi_result;
    end
  end

  always_comb begin
    evt_cnt_o = '0;
    for (int k = 0; k < N_EVT; k++) evt_cnt_o[k*CNT_W +: CNT_W] = evt_q[k];
  end

  assign cycles_o    = cycles_q;
  assign instr_o     = instr_q;
  assign cpi_o       = cpi_q;
  assign overflow_o  = overflow_q;
  assign running_o   = (state_q == S_RUN);
  assign cpi_valid_o = (state_q == S_DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: a 32-bit and a 4-bit counter instance share stimulus and are
// compared against a count-then-derive reference model (wrap or saturate follows PERF_SATURATE_EN).
`timescale 1ns/1ps
module tb_perf_monitor;

  localparam int          FRAC    = 8;
  localparam logic [31:0] END_VAL = 32'h90;

  logic        clk = 1'b0;
  logic        reset_i, start_i, stop_i, clear_i, retire_i, result_valid_i;
  logic [3:0]  evt_i;
  logic [31:0] result_i;

  logic [31:0]  cycles_o, instr_o, cpi_o;
  logic [127:0] evt_cnt_o;
  logic         running_o, cpi_valid_o, overflow_o;
  logic [3:0]   cycles4, instr4, cpi4;
  logic [15:0]  evt_cnt4;
  logic         running4, cpi_valid4, overflow4;

  int checks   = 0;
  int failures = 0;

  perf_monitor dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .retire_i(retire_i), .evt_i(evt_i), .result_valid_i(result_valid_i), .result_i(result_i),
    .cycles_o(cycles_o), .instr_o(instr_o), .evt_cnt_o(evt_cnt_o), .cpi_o(cpi_o),
    .running_o(running_o), .cpi_valid_o(cpi_valid_o), .overflow_o(overflow_o)
  );

  perf_monitor #(.CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .retire_i(retire_i), .evt_i(evt_i), .result_valid_i(result_valid_i), .result_i(result_i),
    .cycles_o(cycles4), .instr_o(instr4), .evt_cnt_o(evt_cnt4), .cpi_o(cpi4),
    .running_o(running4), .cpi_valid_o(cpi_valid4), .overflow_o(overflow4)
  );

  wire any_out = |{cycles_o, instr_o, evt_cnt_o, cpi_o, running_o, cpi_valid_o, overflow_o,
                   cycles4, instr4, evt_cnt4, cpi4, running4, cpi_valid4, overflow4};

  always #5 clk = ~clk;

  function automatic longint lim(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  // Value a w-bit counter shows after raw increments.
  function automatic longint exp_cnt(input longint raw, input int w);
`ifdef PERF_SATURATE_EN
    return (raw > lim(w)) ? lim(w) : raw;
`else
    return raw % (lim(w) + 1);
`endif
  endfunction

  function automatic longint exp_cpi(input longint c, input longint i, input int w);
    longint q;
    if (i == 0) return lim(w);
    q = (c << FRAC) / i;
    return (q > lim(w)) ? lim(w) : q;
  endfunction

  task automatic idle_inputs();
    start_i = 0; stop_i = 0; clear_i = 0; retire_i = 0; evt_i = '0;
    result_valid_i = 0; result_i = '0;
  endtask

  // close_kind: 0 stop, 1 END_VALUE match, 2 both together.
  task automatic run_window(input int n, input bit rnd, input logic [63:0] ret_mask,
                            input logic [3:0] evt_val, input int close_kind,
                            input bit start_stop, input bit wait_done);
    longint raw_cyc, raw_ins, ec, ei, ec4, ei4, e;
    longint raw_evt [4];
    int     lat, lat32, lat4, el32, el4, ck;
    bit     ovf, leak;
    logic   ret;
    logic [3:0] ev;
    raw_cyc = 0; raw_ins = 0; leak = 0;
    for (int k = 0; k < 4; k++) raw_evt[k] = 0;
    @(negedge clk);
    start_i = 1; stop_i = start_stop;
    @(negedge clk);
    checks++;
    if (running_o !== 1'b1 || running4 !== 1'b1)
      $display("FAIL window_open: running=%b/%b expected 1/1", running_o, running4);
    start_i = 0; stop_i = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        ret = 1'($urandom); ev = 4'($urandom); ck = int'($urandom_range(0, 2));
        start_i = 1'($urandom); result_valid_i = 1'($urandom); result_i = $urandom;
        if (result_i == END_VAL) result_i = result_i + 1;
      end else begin
        ret = ret_mask[i]; ev = evt_val; ck = close_kind;
      end
      retire_i = ret; evt_i = ev;
      if (i == n - 1) begin
        stop_i = (ck != 1);
        if (ck != 0) begin result_valid_i = 1; result_i = END_VAL; end
      end
      raw_cyc++;
      raw_ins += longint'(ret);
      for (int k = 0; k < 4; k++) raw_evt[k] += longint'(ev[k]);
      @(negedge clk);
    end
    idle_inputs();
    if (failures < 0) failures = 0;
    ec = exp_cnt(raw_cyc, 32); ei = exp_cnt(raw_ins, 32);
    ec4 = exp_cnt(raw_cyc, 4); ei4 = exp_cnt(raw_ins, 4);
    checks++;
    if (running_o !== 1'b0 || running4 !== 1'b0 || cpi_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL window_close: running=%b/%b valid=%b expected 0/0 0", running_o, running4, cpi_valid_o);
    end
    checks++;
    if (cycles_o !== 32'(ec) || cycles4 !== 4'(ec4)) begin
      failures++;
      $display("FAIL cycles: got %0d/%0d expected %0d/%0d", cycles_o, cycles4, ec, ec4);
    end
    checks++;
    if (instr_o !== 32'(ei) || instr4 !== 4'(ei4)) begin
      failures++;
      $display("FAIL instr: got %0d/%0d expected %0d/%0d", instr_o, instr4, ei, ei4);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      e = exp_cnt(raw_evt[k], 32);
      if (evt_cnt_o[k*32 +: 32] !== 32'(e) || evt_cnt4[k*4 +: 4] !== 4'(exp_cnt(raw_evt[k], 4))) begin
        failures++;
        $display("FAIL evt%0d: got %0d/%0d expected %0d/%0d", k, evt_cnt_o[k*32 +: 32],
                 evt_cnt4[k*4 +: 4], e, exp_cnt(raw_evt[k], 4));
      end
    end
    ovf = (raw_cyc > lim(4)) || (raw_ins > lim(4));
    for (int k = 0; k < 4; k++) ovf = ovf || (raw_evt[k] > lim(4));
    checks++;
    if (overflow_o !== 1'b0 || overflow4 !== ovf) begin
      failures++;
      $display("FAIL overflow: got %b/%b expected 0/%b", overflow_o, overflow4, ovf);
    end
    if (wait_done) begin
      el32 = (ei == 0) ? 1 : 40;
      el4  = (ei4 == 0) ? 1 : 12;
      lat = 0; lat32 = -1; lat4 = -1;
      while ((lat32 < 0 || lat4 < 0) && lat < 100) begin
        if (cpi_valid_o === 1'b1 && lat32 < 0) lat32 = lat;
        if (cpi_valid4 === 1'b1 && lat4 < 0) lat4 = lat;
        if (cpi_valid_o !== 1'b1 && cpi_o !== '0) leak = 1;
        if (cpi_valid4 !== 1'b1 && cpi4 !== '0) leak = 1;
        if (lat32 < 0 || lat4 < 0) begin
          @(negedge clk);
          lat++;
        end
      end
      checks++;
      if (lat32 != el32 || lat4 != el4) begin
        failures++;
        $display("FAIL cpi_latency: got %0d/%0d expected %0d/%0d", lat32, lat4, el32, el4);
      end
      checks++;
      if (leak) begin
        failures++;
        $display("FAIL cpi_early: cpi_o nonzero before cpi_valid_o, expected 0");
      end
      checks++;
      if (cpi_o !== 32'(exp_cpi(ec, ei, 32)) || cpi4 !== 4'(exp_cpi(ec4, ei4, 4))) begin
        failures++;
        $display("FAIL cpi: got %0h/%0h expected %0h/%0h", cpi_o, cpi4,
                 exp_cpi(ec, ei, 32), exp_cpi(ec4, ei4, 4));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (cpi_valid_o !== 1'b1 || cpi_valid4 !== 1'b1 || cpi_o !== 32'(exp_cpi(ec, ei, 32))) begin
        failures++;
        $display("FAIL done_hold: valid=%b/%b cpi=%0h expected 1/1 %0h", cpi_valid_o, cpi_valid4,
                 cpi_o, exp_cpi(ec, ei, 32));
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1; start_i = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (any_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: some output is %b, expected all 0", any_out);
    end
    start_i = 0;
    @(negedge clk);
    reset_i = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (any_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: some output is %b, expected all 0", any_out);
    end
  endtask

  task automatic test_basic_cpi();
    run_window(10, 0, 64'h2AA, 4'b0000, 0, 0, 1);
    checks++;
    if (cpi_o !== 32'h200) begin
      failures++;
      $display("FAIL cpi_10_5: got %0h expected 200", cpi_o);
    end
  endtask

  task automatic test_end_value();
    run_window(7, 0, 64'h15, 4'b0000, 1, 0, 1);
    checks++;
    if (cpi_o !== 32'h255) begin
      failures++;
      $display("FAIL cpi_7_3: got %0h expected 255", cpi_o);
    end
  endtask

  task automatic test_zero_instr();
    run_window(4, 0, 64'h0, 4'b0000, 0, 0, 1);
  endtask

  task automatic test_events();
    run_window(6, 0, 64'h3F, 4'b0101, 0, 0, 1);
  endtask

  task automatic test_simultaneous();
    @(negedge clk); clear_i = 1;
    @(negedge clk); clear_i = 0;
    run_window(5, 0, 64'h1F, 4'b1000, 2, 1, 1);
  endtask

  task automatic test_overflow();
    run_window(20, 0, 64'hFFFFF, 4'b0000, 0, 0, 1);
  endtask

  task automatic test_clear_div();
    run_window(9, 0, 64'h1FF, 4'b0011, 0, 0, 0);
    repeat (3) @(negedge clk);
    clear_i = 1; start_i = 1;
    @(negedge clk);
    checks++;
    if (any_out !== 1'b0) begin
      failures++;
      $display("FAIL clear_in_div: some output is %b, expected all 0", any_out);
    end
    clear_i = 0; start_i = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (any_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_clear: some output is %b, expected all 0", any_out);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0; retire_i = 1; evt_i = 4'hF;
    repeat (3) @(negedge clk);
    #2 reset_i = 1;
    #1;
    checks++;
    if (any_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: some output is %b between edges, expected all 0", any_out);
    end
    @(negedge clk);
    reset_i = 0; retire_i = 0; evt_i = '0;
    @(negedge clk);
    checks++;
    if (any_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_async_reset: some output is %b, expected all 0", any_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 8; w++) begin
      run_window(int'($urandom_range(1, 40)), 1, 64'h0, 4'b0000, 0, 0, 1);
    end
  endtask

  initial begin
    idle_inputs();
    reset_i = 1;
    test_reset();
    test_basic_cpi();
    test_end_value();
    test_zero_instr();
    test_events();
    test_simultaneous();
    test_overflow();
    test_clear_div();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
